// File: rtl/afifo_rd_burst.sv
// Read-side burst framer for an async FIFO: pops words into a 2-entry head/skid
// buffer and tags each beat with a burst-last flag from a programmable length.
module afifo_rd_burst #(
    parameter int DW  = 128,
    parameter int BLW = 8
) (
    input  logic           clk,
    input  logic           reset,
    output logic           fifo_re,
    input  logic           fifo_rempty,
    input  logic [DW-1:0]  fifo_q,
    input  logic [BLW-1:0] burst_len,
    output logic           o_valid,
    input  logic           o_ready,
    output logic [DW-1:0]  o_data,
    output logic           o_last,
    output logic           burst_done
);

    function automatic logic beat_is_last(input logic [BLW-1:0] pos,
                                          input logic [BLW-1:0] len);
        return (pos == len);
    endfunction

    logic [1:0]     cnt;
    logic [BLW-1:0] bcnt;
    logic [BLW-1:0] len_q;
    logic [BLW-1:0] eff_len;
    logic           vld_p0;
    logic [DW-1:0]  head_data_p0;
    logic [DW-1:0]  skid_data_p0;
    logic           head_last_p0;
    logic           skid_last_p0;
    logic           load;
    logic           pop;
    logic           ld_last;

    // Pop decision uses only occupancy so o_ready never reaches the FIFO port.
    assign fifo_re = !reset && !fifo_rempty && (cnt != 2'd2);
    assign load    = fifo_re;
    assign vld_p0  = (cnt != 2'd0);
    assign pop     = vld_p0 && o_ready;

    // The first beat of a burst compares against the live length before it is latched.
    assign eff_len = (bcnt == '0) ? burst_len : len_q;
    assign ld_last = beat_is_last(bcnt, eff_len);

    assign o_valid = vld_p0;
    assign o_data  = head_data_p0;
    assign o_last  = head_last_p0;

    // Stage p0: head/skid buffer and burst position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= 2'd0;
            bcnt         <= '0;
            len_q        <= '0;
            burst_done   <= 1'b0;
            head_data_p0 <= '0;
            head_last_p0 <= 1'b0;
            skid_data_p0 <= '0;
            skid_last_p0 <= 1'b0;
        end else begin
            burst_done <= pop && head_last_p0;
            if (load) begin
                if (bcnt == '0)
                    len_q <= burst_len;
                bcnt <= ld_last ? '0 : bcnt + 1'b1;
            end
            case ({load, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        head_data_p0 <= fifo_q;
                        head_last_p0 <= ld_last;
                    end else begin
                        skid_data_p0 <= fifo_q;
                        skid_last_p0 <= ld_last;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head_data_p0 <= skid_data_p0;
                    head_last_p0 <= skid_last_p0;
                    cnt          <= cnt - 2'd1;
                end
                2'b11: begin
                    head_data_p0 <= fifo_q;
                    head_last_p0 <= ld_last;
                end
                default: ;
            endcase
        end
    end

endmodule
